// File: rtl/branch_control_unit.sv
// Instruction-sequencing control unit for the accumulator processor: fetch PC,
// opcode decode into datapath strobes, branches, call/return stack and halt.
module branch_control_unit #(
  parameter int BITS        = 16,
  parameter int OPBITS      = 5,
  parameter int ADDRBITS    = BITS - OPBITS,
  parameter int STACK_DEPTH = 4,
  parameter int SPBITS      = $clog2(STACK_DEPTH + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [BITS-1:0]     i_instr,
  input  logic                i_instr_valid,
  input  logic                i_zero,
  output logic [ADDRBITS-1:0] o_imem_addr,
  output logic [ADDRBITS-1:0] o_operand,
  output logic [1:0]          o_sel_A,
  output logic                o_sel_B,
  output logic                o_op,
  output logic                o_w_acc,
  output logic                o_w_ram,
  output logic                o_r_ram,
  output logic                o_halt,
  output logic                o_stack_err,
  output logic [SPBITS-1:0]   o_stack_lvl
);

  localparam int IDXBITS     = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int STK_ENTRIES = 1 << IDXBITS;

  localparam logic [OPBITS-1:0] OP_HLT  = OPBITS'(0);
  localparam logic [OPBITS-1:0] OP_STO  = OPBITS'(1);
  localparam logic [OPBITS-1:0] OP_LD   = OPBITS'(2);
  localparam logic [OPBITS-1:0] OP_LDI  = OPBITS'(3);
  localparam logic [OPBITS-1:0] OP_ADD  = OPBITS'(4);
  localparam logic [OPBITS-1:0] OP_ADDI = OPBITS'(5);
  localparam logic [OPBITS-1:0] OP_SUB  = OPBITS'(6);
  localparam logic [OPBITS-1:0] OP_SUBI = OPBITS'(7);
  localparam logic [OPBITS-1:0] OP_JMP  = OPBITS'(8);
  localparam logic [OPBITS-1:0] OP_BEQ  = OPBITS'(9);
  localparam logic [OPBITS-1:0] OP_BNE  = OPBITS'(10);
  localparam logic [OPBITS-1:0] OP_CALL = OPBITS'(11);
  localparam logic [OPBITS-1:0] OP_RET  = OPBITS'(12);

  localparam logic [SPBITS-1:0]   LVL_FULL  = SPBITS'(STACK_DEPTH);
  localparam logic [SPBITS-1:0]   LVL_EMPTY = SPBITS'(0);
  localparam logic [SPBITS-1:0]   LVL_ONE   = SPBITS'(1);
  localparam logic [ADDRBITS-1:0] PC_ONE    = ADDRBITS'(1);

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  state_t                state_r, state_next_s;
  logic [ADDRBITS-1:0]   pc_r, pc_next_s, pc_inc_s;
  logic [SPBITS-1:0]     lvl_r, lvl_next_s, lvl_dec_s;
  logic                  err_r, err_next_s;
  logic                  halt_r;
  logic                  push_s;
  logic                  exec_s;
  logic [OPBITS-1:0]     opcode_s;
  logic [ADDRBITS-1:0]   operand_s;
  logic [IDXBITS-1:0]    push_idx_s, pop_idx_s;
  logic [ADDRBITS-1:0]   stack_r [STK_ENTRIES];

  assign exec_s     = (state_r == ST_RUN) && i_instr_valid;
  assign opcode_s   = i_instr[BITS-1 -: OPBITS];
  assign operand_s  = i_instr[ADDRBITS-1:0];
  assign pc_inc_s   = pc_r + PC_ONE;
  assign lvl_dec_s  = lvl_r - LVL_ONE;
  assign push_idx_s = lvl_r[IDXBITS-1:0];
  assign pop_idx_s  = lvl_dec_s[IDXBITS-1:0];

  assign o_imem_addr = pc_r;
  assign o_operand   = operand_s;
  assign o_halt      = halt_r;
  assign o_stack_err = err_r;
  assign o_stack_lvl = lvl_r;

  // State register: PC, stack level, sticky error and halt flag
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r <= ST_RUN;
      pc_r    <= '0;
      lvl_r   <= '0;
      err_r   <= 1'b0;
      halt_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      pc_r    <= pc_next_s;
      lvl_r   <= lvl_next_s;
      err_r   <= err_next_s;
      halt_r  <= (state_next_s == ST_HALT);
    end
  end

  // Return-address storage; contents deliberately survive reset
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      stack_r[push_idx_s] <= pc_inc_s;
    end
  end

  // Next-state: sequencing, branch resolution and stack bounds checks
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    lvl_next_s   = lvl_r;
    err_next_s   = err_r;
    push_s       = 1'b0;
    if (exec_s) begin
      case (opcode_s)
        OP_HLT: state_next_s = ST_HALT;
        OP_JMP: pc_next_s = operand_s;
        OP_BEQ: pc_next_s = i_zero ? operand_s : pc_inc_s;
        OP_BNE: pc_next_s = i_zero ? pc_inc_s : operand_s;
        OP_CALL: begin
          if (lvl_r == LVL_FULL) begin
            err_next_s   = 1'b1;
            state_next_s = ST_HALT;
          end else begin
            push_s     = 1'b1;
            lvl_next_s = lvl_r + LVL_ONE;
            pc_next_s  = operand_s;
          end
        end
        OP_RET: begin
          if (lvl_r == LVL_EMPTY) begin
            err_next_s   = 1'b1;
            state_next_s = ST_HALT;
          end else begin
            lvl_next_s = lvl_dec_s;
            pc_next_s  = stack_r[pop_idx_s];
          end
        end
        default: pc_next_s = pc_inc_s;
      endcase
    end else begin
      pc_next_s = pc_r;
    end
  end

  // Output decode: datapath strobes, all zero unless executing
  always_comb begin
    o_sel_A = 2'b00;
    o_sel_B = 1'b0;
    o_op    = 1'b0;
    o_w_acc = 1'b0;
    o_w_ram = 1'b0;
    o_r_ram = 1'b0;
    if (exec_s) begin
      case (opcode_s)
        OP_STO: o_w_ram = 1'b1;
        OP_LD: begin
          o_r_ram = 1'b1;
          o_w_acc = 1'b1;
        end
        OP_LDI: begin
          o_w_acc = 1'b1;
          o_sel_A = 2'b01;
        end
        OP_ADD, OP_SUB: begin
          o_r_ram = 1'b1;
          o_w_acc = 1'b1;
          o_sel_A = 2'b10;
          o_op    = (opcode_s == OP_SUB);
        end
        OP_ADDI, OP_SUBI: begin
          o_w_acc = 1'b1;
          o_sel_A = 2'b10;
          o_sel_B = 1'b1;
          o_op    = (opcode_s == OP_SUBI);
        end
        default: o_sel_A = 2'b00;
      endcase
    end else begin
      o_sel_A = 2'b00;
    end
  end

endmodule

// File: tb/tb_branch_control_unit.sv
// Directed self-checking bench for branch_control_unit with default parameters.
module tb_branch_control_unit;

  localparam logic [4:0] HLT = 5'd0, STO = 5'd1, LD = 5'd2, LDI = 5'd3, ADD = 5'd4,
                         ADDI = 5'd5, SUB = 5'd6, SUBI = 5'd7, JMP = 5'd8, BEQ = 5'd9,
                         BNE = 5'd10, CALL = 5'd11, RET = 5'd12, NOP = 5'd31;
  // strobe vector: {sel_A[1:0], sel_B, op, w_acc, w_ram, r_ram}
  localparam logic [6:0] S_NONE = 7'b00_0_0_0_0_0, S_STO = 7'b00_0_0_0_1_0,
                         S_LD = 7'b00_0_0_1_0_1, S_LDI = 7'b01_0_0_1_0_0,
                         S_ADD = 7'b10_0_0_1_0_1, S_ADDI = 7'b10_1_0_1_0_0,
                         S_SUB = 7'b10_0_1_1_0_1, S_SUBI = 7'b10_1_1_1_0_0;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [15:0] i_instr = 16'd0;
  logic        i_instr_valid = 1'b0;
  logic        i_zero = 1'b0;
  logic [10:0] o_imem_addr, o_operand;
  logic [1:0]  o_sel_A;
  logic        o_sel_B, o_op, o_w_acc, o_w_ram, o_r_ram, o_halt, o_stack_err;
  logic [2:0]  o_stack_lvl;
  logic [6:0]  strb;

  int n_checks = 0;
  int n_fail = 0;

  branch_control_unit dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_instr(i_instr), .i_instr_valid(i_instr_valid),
    .i_zero(i_zero), .o_imem_addr(o_imem_addr), .o_operand(o_operand),
    .o_sel_A(o_sel_A), .o_sel_B(o_sel_B), .o_op(o_op), .o_w_acc(o_w_acc),
    .o_w_ram(o_w_ram), .o_r_ram(o_r_ram), .o_halt(o_halt),
    .o_stack_err(o_stack_err), .o_stack_lvl(o_stack_lvl)
  );

  assign strb = {o_sel_A, o_sel_B, o_op, o_w_acc, o_w_ram, o_r_ram};

  always #5 i_clk = ~i_clk;

  task automatic drive(input logic [4:0] op, input logic [10:0] opd, input logic valid,
                       input logic zero);
    i_instr = {op, opd};
    i_instr_valid = valid;
    i_zero = zero;
    #1;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b0;
    i_instr_valid = 1'b0;
    #1;
    @(negedge i_clk);
    i_rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    drive(LDI, 11'd9, 1'b0, 1'b0);
    n_checks++; if (o_imem_addr !== 11'd0) begin n_fail++; $display("FAIL reset_pc act=%0d exp=0", o_imem_addr); end
    n_checks++; if (o_stack_lvl !== 3'd0) begin n_fail++; $display("FAIL reset_lvl act=%0d exp=0", o_stack_lvl); end
    n_checks++; if (o_stack_err !== 1'b0) begin n_fail++; $display("FAIL reset_err act=%0b exp=0", o_stack_err); end
    n_checks++; if (o_halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt act=%0b exp=0", o_halt); end
    n_checks++; if (strb !== S_NONE) begin n_fail++; $display("FAIL reset_strobes act=%b exp=%b", strb, S_NONE); end
    do_reset();
  endtask

  task automatic test_decode();
    logic [4:0]  ops [8]  = '{STO, LD, LDI, ADD, ADDI, SUB, SUBI, NOP};
    logic [6:0]  exps [8] = '{S_STO, S_LD, S_LDI, S_ADD, S_ADDI, S_SUB, S_SUBI, S_NONE};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(ops[i], 11'(100 + i), 1'b1, 1'b0);
      n_checks++; if (strb !== exps[i]) begin n_fail++; $display("FAIL decode_strobes[%0d] act=%b exp=%b", i, strb, exps[i]); end
      n_checks++; if (o_operand !== 11'(100 + i)) begin n_fail++; $display("FAIL decode_operand[%0d] act=%0d exp=%0d", i, o_operand, 100 + i); end
      tick();
      n_checks++; if (o_imem_addr !== 11'(i + 1)) begin n_fail++; $display("FAIL decode_pc[%0d] act=%0d exp=%0d", i, o_imem_addr, i + 1); end
    end
  endtask

  task automatic test_straight_line();
    logic [4:0]  ops [4]  = '{LDI, ADDI, STO, HLT};
    logic [10:0] opds [4] = '{11'd5, 11'd3, 11'd7, 11'd0};
    logic [6:0]  exps [4] = '{S_LDI, S_ADDI, S_STO, S_NONE};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], opds[i], 1'b1, 1'b0);
      n_checks++; if (o_imem_addr !== 11'(i)) begin n_fail++; $display("FAIL straight_pc[%0d] act=%0d exp=%0d", i, o_imem_addr, i); end
      n_checks++; if (strb !== exps[i]) begin n_fail++; $display("FAIL straight_strobes[%0d] act=%b exp=%b", i, strb, exps[i]); end
      n_checks++; if (o_halt !== 1'b0) begin n_fail++; $display("FAIL straight_halt_early[%0d] act=%0b exp=0", i, o_halt); end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(LDI, 11'd1, 1'b1, 1'b0);
      n_checks++; if (o_halt !== 1'b1) begin n_fail++; $display("FAIL halt_flag act=%0b exp=1", o_halt); end
      n_checks++; if (o_imem_addr !== 11'd3) begin n_fail++; $display("FAIL halt_pc act=%0d exp=3", o_imem_addr); end
      n_checks++; if (strb !== S_NONE) begin n_fail++; $display("FAIL halt_strobes act=%b exp=%b", strb, S_NONE); end
      tick();
    end
  endtask

  task automatic test_branch();
    logic [4:0]  bops [4] = '{BEQ, BEQ, BNE, BNE};
    logic        zs   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [10:0] tgt  [4] = '{11'd20, 11'd5, 11'd20, 11'd5};
    for (int i = 0; i < 4; i++) begin
      do_reset();
      drive(JMP, 11'd4, 1'b1, 1'b0);
      tick();
      n_checks++; if (o_imem_addr !== 11'd4) begin n_fail++; $display("FAIL jmp_pc[%0d] act=%0d exp=4", i, o_imem_addr); end
      drive(bops[i], 11'd20, 1'b1, zs[i]);
      tick();
      n_checks++; if (o_imem_addr !== tgt[i]) begin n_fail++; $display("FAIL branch_pc[%0d] act=%0d exp=%0d", i, o_imem_addr, tgt[i]); end
    end
    do_reset();
    drive(JMP, 11'd2047, 1'b1, 1'b0);
    tick();
    n_checks++; if (o_imem_addr !== 11'd2047) begin n_fail++; $display("FAIL jmp_top act=%0d exp=2047", o_imem_addr); end
    drive(NOP, 11'd0, 1'b1, 1'b0);
    tick();
    n_checks++; if (o_imem_addr !== 11'd0) begin n_fail++; $display("FAIL pc_wrap act=%0d exp=0", o_imem_addr); end
  endtask

  task automatic test_nested_call();
    logic [4:0]  ops [5]  = '{CALL, CALL, RET, RET, NOP};
    logic [10:0] opds [5] = '{11'd10, 11'd30, 11'd0, 11'd0, 11'd0};
    logic [10:0] pcs [5]  = '{11'd1, 11'd10, 11'd30, 11'd11, 11'd2};
    logic [2:0]  lvls [5] = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd0};
    do_reset();
    drive(JMP, 11'd1, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], opds[i], 1'b1, 1'b0);
      n_checks++; if (o_imem_addr !== pcs[i]) begin n_fail++; $display("FAIL call_pc[%0d] act=%0d exp=%0d", i, o_imem_addr, pcs[i]); end
      n_checks++; if (o_stack_lvl !== lvls[i]) begin n_fail++; $display("FAIL call_lvl[%0d] act=%0d exp=%0d", i, o_stack_lvl, lvls[i]); end
      tick();
    end
  endtask

  task automatic test_stack_errors();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(CALL, 11'(10 * (k + 1)), 1'b1, 1'b0);
      n_checks++; if (o_stack_lvl !== 3'(k)) begin n_fail++; $display("FAIL ovf_lvl[%0d] act=%0d exp=%0d", k, o_stack_lvl, k); end
      tick();
    end
    n_checks++; if (o_stack_lvl !== 3'd4) begin n_fail++; $display("FAIL ovf_final_lvl act=%0d exp=4", o_stack_lvl); end
    n_checks++; if (o_imem_addr !== 11'd40) begin n_fail++; $display("FAIL ovf_pc act=%0d exp=40", o_imem_addr); end
    n_checks++; if (o_stack_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err act=%0b exp=1", o_stack_err); end
    n_checks++; if (o_halt !== 1'b1) begin n_fail++; $display("FAIL ovf_halt act=%0b exp=1", o_halt); end
    do_reset();
    n_checks++; if (o_stack_err !== 1'b0) begin n_fail++; $display("FAIL err_cleared act=%0b exp=0", o_stack_err); end
    drive(RET, 11'd0, 1'b1, 1'b0);
    tick();
    n_checks++; if (o_imem_addr !== 11'd0) begin n_fail++; $display("FAIL udf_pc act=%0d exp=0", o_imem_addr); end
    n_checks++; if (o_stack_lvl !== 3'd0) begin n_fail++; $display("FAIL udf_lvl act=%0d exp=0", o_stack_lvl); end
    n_checks++; if (o_stack_err !== 1'b1) begin n_fail++; $display("FAIL udf_err act=%0b exp=1", o_stack_err); end
    n_checks++; if (o_halt !== 1'b1) begin n_fail++; $display("FAIL udf_halt act=%0b exp=1", o_halt); end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(ADD, 11'd7, 1'b0, 1'b0);
      n_checks++; if (strb !== S_NONE) begin n_fail++; $display("FAIL stall_strobes[%0d] act=%b exp=%b", i, strb, S_NONE); end
      tick();
      n_checks++; if (o_imem_addr !== 11'd0) begin n_fail++; $display("FAIL stall_pc[%0d] act=%0d exp=0", i, o_imem_addr); end
    end
    drive(ADD, 11'd7, 1'b1, 1'b0);
    n_checks++; if (strb !== S_ADD) begin n_fail++; $display("FAIL stall_exec_strobes act=%b exp=%b", strb, S_ADD); end
    tick();
    n_checks++; if (o_imem_addr !== 11'd1) begin n_fail++; $display("FAIL stall_exec_pc act=%0d exp=1", o_imem_addr); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(CALL, 11'd10, 1'b1, 1'b0);
    tick();
    drive(CALL, 11'd20, 1'b1, 1'b0);
    tick();
    drive(NOP, 11'd0, 1'b1, 1'b0);
    n_checks++; if (o_stack_lvl !== 3'd2) begin n_fail++; $display("FAIL arst_pre_lvl act=%0d exp=2", o_stack_lvl); end
    i_rst = 1'b0;
    #1;
    n_checks++; if (o_imem_addr !== 11'd0) begin n_fail++; $display("FAIL arst_pc act=%0d exp=0", o_imem_addr); end
    n_checks++; if (o_stack_lvl !== 3'd0) begin n_fail++; $display("FAIL arst_lvl act=%0d exp=0", o_stack_lvl); end
    n_checks++; if (o_stack_err !== 1'b0) begin n_fail++; $display("FAIL arst_err act=%0b exp=0", o_stack_err); end
    @(negedge i_clk);
    i_rst = 1'b1;
    tick();
    n_checks++; if (o_imem_addr !== 11'd1) begin n_fail++; $display("FAIL arst_restart_pc act=%0d exp=1", o_imem_addr); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_straight_line();
    test_branch();
    test_nested_call();
    test_stack_errors();
    test_stall();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_control_unit.md
# branch_control_unit

Parametrised instruction-sequencing control unit for the accumulator processor, succeeding the fixed-width fetch/decode controller. It fetches from program memory through a valid-qualified address port. It decodes the 5-bit opcode into datapath strobes and adds four things to the basic arithmetic/load/store set: jumps, zero-conditional branches, subroutine calls and returns on a return-address stack of configurable depth, and a halt state. It sits between program memory and the accumulator datapath/data RAM.

## Interface
- BITS, 16, instruction width
- OPBITS, 5, opcode field width; opcode is i_instr[BITS-1:BITS-OPBITS]
- ADDRBITS, BITS-OPBITS, operand/program-address width; operand is i_instr[ADDRBITS-1:0]
- STACK_DEPTH, 4, return-address stack entries (≥1)
- SPBITS, $clog2(STACK_DEPTH+1), stack-level width
- i_clk  in  1  single clock, rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_instr  in  BITS  instruction word at o_imem_addr
- i_instr_valid  in  1  program memory data valid; 0 = stall
- i_zero  in  1  accumulator==0 flag from datapath (registered accumulator)
- o_imem_addr  out  ADDRBITS  program counter
- o_operand  out  ADDRBITS  operand field, passed through unconditionally
- o_sel_A  out  2  accumulator source: 00 RAM, 01 immediate, 10 ALU
- o_sel_B  out  1  ALU B source: 0 RAM, 1 immediate
- o_op  out  1  ALU op: 0 add, 1 sub
- o_w_acc, o_w_ram, o_r_ram  out  1 each  accumulator write, RAM write, RAM read
- o_halt  out  1  core halted
- o_stack_err  out  1  sticky stack overflow/underflow
- o_stack_lvl  out  SPBITS  current stack occupancy

## Operation
- States: RUN, HALT. Reset → RUN. HALT is left only by reset.
- An instruction executes when state==RUN and i_instr_valid=1 ("exec"). Otherwise all strobes are 0, o_sel_A/o_sel_B/o_op are 0, and PC, stack and state hold.
- Decode under exec (unlisted strobes are 0):
  - 00000 HLT: next state HALT; PC holds.
  - 00001 STO: w_ram.
  - 00010 LD: r_ram, w_acc, sel_A=00.
  - 00011 LDI: w_acc, sel_A=01.
  - 00100 ADD: r_ram, w_acc, sel_A=10, sel_B=0, op=0.
  - 00101 ADDI: w_acc, sel_A=10, sel_B=1, op=0.
  - 00110 SUB: as ADD with op=1.
  - 00111 SUBI: as ADDI with op=1.
  - 01000 JMP: PC←operand.
  - 01001 BEQ: PC←operand if i_zero, else PC+1.
  - 01010 BNE: PC←operand if !i_zero, else PC+1.
  - 01011 CALL: push PC+1, then PC←operand.
  - 01100 RET: PC←pop.
  - All other opcodes: NOP, PC+1.
- Non-control instructions advance PC by 1, modulo 2^ADDRBITS; 2^ADDRBITS−1 wraps to 0.
- Stack: LIFO, o_stack_lvl = number of valid entries.
- CALL at lvl==STACK_DEPTH is an overflow: no push, PC holds, o_stack_err←1, state←HALT.
- RET at lvl==0 is an underflow: same response.
- o_stack_err clears only on reset.
- Stack contents are not cleared on reset; only the level is.

## Timing
- Reset (async assert, release synchronous to i_clk): o_imem_addr=0, o_stack_lvl=0, o_stack_err=0, o_halt=0, state RUN. Strobes follow the decode of i_instr combinationally, so they are 0 while i_instr_valid=0.
- Decode is combinational: strobes are valid in the same cycle the instruction is presented.
- PC, stack and state update on the rising edge that ends an exec cycle. The branch target appears on o_imem_addr the next cycle, so there are zero delay slots.
- i_zero is sampled in the BEQ/BNE exec cycle. It reflects the accumulator before that edge.
- CALL/RET: push/pop and the PC update occur on the same edge. RET returns CALL address +1 whatever the calls' depth.
- o_halt asserts the cycle after the HLT or error edge. It is a registered output.
- A stall of any length (i_instr_valid=0) inserts no side effects. The instruction executes in the first valid cycle.
- Reset asserted mid-instruction clears the state immediately, without waiting for a clock edge.

## Test plan
- Reset then straight-line sequence LDI 5, ADDI 3, STO 7, HLT at 0..3 → strobes per decode each cycle, PC 0,1,2,3 then holds at 3, o_halt=1 from the cycle after HLT, with no further strobes.
- BEQ 20 at PC 4: i_zero=1 → next PC 20; i_zero=0 → next PC 5. BNE 20 gives the mirror result. JMP 2^ADDRBITS−1 followed by NOP → PC wraps to 0.
- Nested CALL 10 (at PC 1) → CALL 30 (at PC 10) → RET → RET → PC sequence 1,10,30,11,2; o_stack_lvl 0,1,2,1,0.
- STACK_DEPTH+1 consecutive CALLs → the last does not push, o_stack_err=1, o_halt=1, lvl=STACK_DEPTH. RET at reset (lvl 0) → underflow, err=1, halted at PC 0.
- i_instr_valid low for 3 cycles under ADD → all strobes 0, PC constant. On the valid cycle ADD strobes once and PC+1.
- Reset asserted asynchronously mid-CALL sequence with lvl=2 → PC=0, lvl=0, err=0 before the next edge, and execution restarts from 0.
